// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the processor data-memory stage.
// The optional statistics counters are enabled with the DMEM_STATS_EN macro.
package dmem_pkg;

    localparam int DMEM_DATA_W     = 32;
    localparam int DMEM_ADDR_W     = 8;
    localparam int DMEM_WBUF_DEPTH = 4;
    localparam int WBUF_PTR_W      = $clog2(DMEM_WBUF_DEPTH);

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/dmem_wbuf.sv
// Circular posted-write FIFO with a combinational youngest-match lookup
// so reads can be served from entries that have not yet drained.
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int WBUF_DEPTH = DMEM_WBUF_DEPTH,
    localparam int PTR_W     = $clog2(WBUF_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  wbuf_entry_t            push_entry,
    output wbuf_entry_t            head_entry,
    output logic                   full,
    output logic                   empty,
    output logic [PTR_W:0]         count,
    input  logic [DMEM_ADDR_W-1:0] lk_addr,
    output logic                   lk_hit,
    output logic [DMEM_DATA_W-1:0] lk_data
);

    wbuf_entry_t          entries [WBUF_DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W:0]       count_nxt;

    assign full       = (count == (PTR_W+1)'(WBUF_DEPTH));
    assign head_entry = entries[head];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (PTR_W+1)'(1);
            2'b01:   count_nxt = count - (PTR_W+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Entry storage carries no reset; validity is implied by head/count.
    always_ff @(posedge clk) begin
        if (push)
            entries[tail] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            empty <= 1'b1;
        end else begin
            if (pop)
                head <= head + PTR_W'(1);
            if (push)
                tail <= tail + PTR_W'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (((PTR_W+1)'(i) < count) &&
                (entries[head + PTR_W'(i)].addr == lk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = entries[head + PTR_W'(i)].data;
            end
        end
    end

endmodule

// File: rtl/proc_dmem.sv
// Data-memory stage: posts writes into a small buffer, drains it into a
// single-port array on idle cycles, and forwards buffered data to reads.
// Define DMEM_STATS_EN to add saturating rd_cnt/wr_cnt/fwd_cnt outputs.
module proc_dmem
    import dmem_pkg::*;
#(
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int WBUF_DEPTH = DMEM_WBUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wbuf_empty
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       fwd_cnt
`endif
);

    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam int PTR_W     = $clog2(WBUF_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              full;
    logic [PTR_W:0]    count;
    wbuf_entry_t       head_entry;
    wbuf_entry_t       push_entry;
    logic              lk_hit;
    logic [DATA_W-1:0] lk_data;

    logic              acc_p0;
    logic              acc_wr_p0;
    logic              acc_rd_p0;
    logic              drain_p0;
    logic [DATA_W-1:0] rd_src_p0;

    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;

    // Stage p0: accept / arbitrate the single array port
    assign ready      = !rst && !full;
    assign acc_p0     = req && ready;
    assign acc_wr_p0  = acc_p0 && we;
    assign acc_rd_p0  = acc_p0 && !we;
    assign drain_p0   = !rst && !acc_p0 && (count != '0);
    assign push_entry = '{addr: address, data: wdata};
    assign rd_src_p0  = lk_hit ? lk_data : mem[address];

    dmem_wbuf #(
        .WBUF_DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .push       (acc_wr_p0),
        .pop        (drain_p0),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .full       (full),
        .empty      (wbuf_empty),
        .count      (count),
        .lk_addr    (address),
        .lk_hit     (lk_hit),
        .lk_data    (lk_data)
    );

    always_ff @(posedge clk) begin
        if (drain_p0)
            mem[head_entry.addr] <= head_entry.data;
    end

    // Stage p1: registered read return; rdata holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= acc_rd_p0;
            if (acc_rd_p0)
                rdata_p1 <= rd_src_p0;
        end
    end

    assign rdata       = rdata_p1;
    assign rdata_valid = vld_p1;

`ifdef DMEM_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            fwd_cnt <= '0;
        end else begin
            if (acc_rd_p0)
                rd_cnt <= sat_inc16(rd_cnt);
            if (acc_wr_p0)
                wr_cnt <= sat_inc16(wr_cnt);
            if (acc_rd_p0 && lk_hit)
                fwd_cnt <= sat_inc16(fwd_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_proc_dmem.sv
// Directed self-checking bench for proc_dmem: reset, drain, forwarding,
// full-buffer stall with pointer wrap, and reset discarding posted writes.
module tb_proc_dmem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [7:0]  address;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        wbuf_empty;
`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, fwd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    proc_dmem dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .we          (we),
        .address     (address),
        .wdata       (wdata),
        .ready       (ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .wbuf_empty  (wbuf_empty)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt),
        .fwd_cnt     (fwd_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        we  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a request and hold it until accepted; stalls counts wait cycles.
    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                         output int stalls);
        req = 1'b1; we = w; address = a; wdata = d;
        stalls = 0;
        while (!ready && stalls < 20) begin
            tick();
            stalls++;
        end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: ready stuck low after %0d cycles, required 1", stalls);
        end
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; we = 1'b0; address = 8'h00; wdata = '0;
        tick();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", ready); end
        tick();
        checks++;
        if (rdata_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", rdata_valid); end
        checks++;
        if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b required 1", wbuf_empty); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h required 00000000", rdata); end
        rst = 1'b0; req = 1'b0;
        tick();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b required 1", ready); end
        checks++;
        if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL rel_empty: got %b required 1", wbuf_empty); end
    endtask

    task automatic test_drain();
        int s;
        issue(1'b1, 8'h10, 32'h0000_0005, s);
        checks++;
        if (wbuf_empty !== 1'b0) begin errors++; $display("FAIL drain_pending: wbuf_empty got %b required 0", wbuf_empty); end
        idle(2);
        checks++;
        if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b required 1", wbuf_empty); end
        issue(1'b0, 8'h10, 32'h0, s);
        checks++;
        if (rdata_valid !== 1'b1 || rdata !== 32'h0000_0005) begin
            errors++; $display("FAIL drain_read: got v=%b %h required v=1 00000005", rdata_valid, rdata);
        end
        idle(1);
        checks++;
        if (rdata_valid !== 1'b0 || rdata !== 32'h0000_0005) begin
            errors++; $display("FAIL rdata_hold: got v=%b %h required v=0 00000005", rdata_valid, rdata);
        end
    endtask

    task automatic test_back_to_back();
        int s;
        issue(1'b1, 8'h20, 32'hAAAA_0000, s);
        issue(1'b1, 8'h20, 32'hBBBB_0000, s);
        issue(1'b0, 8'h20, 32'h0, s);
        checks++;
        if (rdata_valid !== 1'b1 || rdata !== 32'hBBBB_0000) begin
            errors++; $display("FAIL fwd_young: got v=%b %h required v=1 bbbb0000", rdata_valid, rdata);
        end
        checks++;
        if (wbuf_empty !== 1'b0) begin errors++; $display("FAIL fwd_nodrain: wbuf_empty got %b required 0", wbuf_empty); end
`ifdef DMEM_STATS_EN
        checks++;
        if (fwd_cnt !== 16'd1) begin errors++; $display("FAIL fwd_cnt: got %0d required 1", fwd_cnt); end
`endif
        // Read squeezed between writes must still see the buffered value.
        issue(1'b1, 8'h40, 32'h0000_0007, s);
        issue(1'b0, 8'h40, 32'h0, s);
        checks++;
        if (rdata_valid !== 1'b1 || rdata !== 32'h0000_0007) begin
            errors++; $display("FAIL fwd_stream: got v=%b %h required v=1 00000007", rdata_valid, rdata);
        end
        idle(4);
        issue(1'b0, 8'h20, 32'h0, s);
        checks++;
        if (rdata !== 32'hBBBB_0000 || wbuf_empty !== 1'b1) begin
            errors++; $display("FAIL arr_after_drain: got %h empty=%b required bbbb0000 empty=1", rdata, wbuf_empty);
        end
    endtask

    task automatic test_full_stall();
        int s;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 8'(i), 32'(i + 1), s);
            checks++;
            if (s !== 0) begin errors++; $display("FAIL fill_stall%0d: got %0d required 0", i, s); end
        end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", ready); end
        issue(1'b1, 8'h04, 32'h0000_0005, s);
        checks++;
        if (s !== 1) begin errors++; $display("FAIL full_stall: got %0d required 1", s); end
        idle(6);
        checks++;
        if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL full_drained: got %b required 1", wbuf_empty); end
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 8'(i), 32'h0, s);
            checks++;
            if (rdata_valid !== 1'b1 || rdata !== 32'(i + 1)) begin
                errors++; $display("FAIL wrap_read%0d: got v=%b %h required v=1 %h", i, rdata_valid, rdata, 32'(i + 1));
            end
        end
    endtask

    task automatic test_reset_discard();
        int s;
        issue(1'b1, 8'h30, 32'hCAFE_F00D, s);
        idle(2);
        issue(1'b1, 8'h30, 32'h1234_5678, s);
        rst = 1'b1;
        tick();
        checks++;
        if (rdata_valid !== 1'b0 || wbuf_empty !== 1'b1) begin
            errors++; $display("FAIL mid_rst: got v=%b empty=%b required v=0 empty=1", rdata_valid, wbuf_empty);
        end
        rst = 1'b0;
        tick();
        issue(1'b0, 8'h30, 32'h0, s);
        checks++;
        if (rdata_valid !== 1'b1 || rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL discard_read: got v=%b %h required v=1 cafef00d", rdata_valid, rdata);
        end
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats_sat();
        int s;
        for (int i = 0; i < 65540; i++) issue(1'b1, 8'h80, 32'(i), s);
        checks++;
        if (wr_cnt !== 16'hFFFF) begin errors++; $display("FAIL wr_cnt_sat: got %h required ffff", wr_cnt); end
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_drain();
        test_back_to_back();
        test_full_stall();
        test_reset_discard();
`ifdef DMEM_STATS_EN
        test_stats_sat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
